mem_arbiter: RTL

- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and data-memory port.
- Sits between the pipeline core and the unified memory.
- Sequences each access as a request/acknowledge transaction and returns read data through per-port one-cycle ready pulses.
- Raises a stall that the core uses to freeze PC, IF/ID and later stages.
- Data accesses have priority; a starvation limit guarantees fetch progress.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_D,
      RESP
   } arb_state_t;

   function automatic int starve_cnt_w(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and
// data access; data has priority, bounded by a starvation limit that forces fetch progress.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int               CNT_W = starve_cnt_w(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_sel_d;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic [CNT_W-1:0]  r_starve_cnt;

   logic              w_d_req;
   logic              w_grant_d;
   logic              w_grant_if;
   logic              w_done;
   logic              w_if_ready;
   logic              w_d_ready;

   assign w_d_req    = d_read | d_write;
   // Data wins unless a fetch is waiting and data has used up its consecutive-grant quota.
   assign w_grant_d  = (r_state == IDLE) && w_d_req && !(if_req && (r_starve_cnt == LIMIT));
   assign w_grant_if = (r_state == IDLE) && if_req && !w_grant_d;
   assign w_done     = ((r_state == BUSY_IF) || (r_state == BUSY_D)) && mem_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_d)       w_state_nxt = BUSY_D;
            else if (w_grant_if) w_state_nxt = BUSY_IF;
         end
         BUSY_IF, BUSY_D: begin
            if (mem_ack) w_state_nxt = RESP;
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_if_ready = 1'b0;
      w_d_ready  = 1'b0;
      if (r_state == RESP) begin
         w_if_ready = ~r_sel_d;
         w_d_ready  = r_sel_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sel_d     <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
      end else if (w_grant_d) begin
         r_sel_d     <= 1'b1;
         r_mem_req   <= 1'b1;
         r_mem_we    <= d_write;
         r_mem_addr  <= d_addr;
         r_mem_wdata <= d_wdata;
      end else if (w_grant_if) begin
         r_sel_d     <= 1'b0;
         r_mem_req   <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= if_addr;
         r_mem_wdata <= d_wdata;
      end else if (w_done) begin
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
         if (r_state == BUSY_IF)  r_if_rdata <= mem_rdata;
         else if (!r_mem_we)      r_d_rdata  <= mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve_cnt <= '0;
      end else if (w_grant_d) begin
         if (if_req && (r_starve_cnt != LIMIT)) r_starve_cnt <= r_starve_cnt + 1'b1;
      end else if (w_grant_if) begin
         r_starve_cnt <= '0;
      end
   end

   assign if_ready  = w_if_ready;
   assign d_ready   = w_d_ready;
   assign stall     = (if_req & ~w_if_ready) | (w_d_req & ~w_d_ready);
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;

endmodule
